// File: rtl/ex_hazard_ctrl.sv
// Execute-stage sequencing controller: owns every stall/flush/redirect
// decision (load-use stalls, taken redirects, RET wait, halt, error).
module ex_hazard_ctrl #(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned RET_TIMEOUT       = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid,
    input  logic [3:0] id_rs1,
    input  logic [3:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic       id_ret,
    input  logic       id_halt,
    input  logic       ex_mem_read,
    input  logic [3:0] ex_reg_rd,
    input  logic       ex_pc_update_done,
    input  logic       ex_pc_src,
    input  logic       mem_ret_wb,
    output logic       pc_write,
    output logic       ifid_write,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       pc_sel_update,
    output logic       halted,
    output logic       err,
    output logic [2:0] state
);

    localparam int unsigned CNT_W = 4;
    localparam bit          MULTI_STALL = (LOAD_STALL_CYCLES > 1);
    localparam logic [CNT_W-1:0] STALL_INIT =
        CNT_W'(MULTI_STALL ? LOAD_STALL_CYCLES - 2 : 0);
    localparam logic [CNT_W-1:0] RET_INIT = CNT_W'(RET_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_RUN        = 3'd0,
        ST_LOAD_STALL = 3'd1,
        ST_RET_WAIT   = 3'd2,
        ST_HALT       = 3'd3,
        ST_ERROR      = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             luh;
    logic             tk;

    // Hazard and redirect qualifiers; r0 is never a hazard source
    assign luh = id_valid & ex_mem_read & (ex_reg_rd != 4'd0) &
                 ((id_uses_rs1 & (id_rs1 == ex_reg_rd)) |
                  (id_uses_rs2 & (id_rs2 == ex_reg_rd)));
    assign tk  = ex_pc_update_done & ex_pc_src;

    assign state = state_q;

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (tk) begin
                    state_d = ST_RUN;
                end else if (id_valid && id_halt) begin
                    state_d = ST_HALT;
                end else if (id_valid && id_ret) begin
                    state_d = ST_RET_WAIT;
                    cnt_d   = RET_INIT;
                end else if (luh && MULTI_STALL) begin
                    state_d = ST_LOAD_STALL;
                    cnt_d   = STALL_INIT;
                end
            end
            ST_LOAD_STALL: begin
                if (tk || (cnt_q == '0)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RET_WAIT: begin
                if (mem_ret_wb) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_ERROR;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HALT:  state_d = ST_HALT;
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_ERROR;
        endcase
    end

    // Pipeline control outputs, combinational from state and inputs
    always_comb begin
        pc_write      = 1'b1;
        ifid_write    = 1'b1;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        pc_sel_update = 1'b0;
        halted        = 1'b0;
        err           = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (tk) begin
                    ifid_flush    = 1'b1;
                    idex_flush    = 1'b1;
                    pc_sel_update = 1'b1;
                end else if (id_valid && id_halt) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                end else if (id_valid && id_ret) begin
                    pc_write = 1'b1;
                end else if (luh) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                end
            end
            ST_LOAD_STALL: begin
                if (tk) begin
                    ifid_flush    = 1'b1;
                    idex_flush    = 1'b1;
                    pc_sel_update = 1'b1;
                end else begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                end
            end
            ST_RET_WAIT: begin
                pc_write   = 1'b0;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                if (mem_ret_wb) begin
                    pc_write      = 1'b1;
                    pc_sel_update = 1'b1;
                end
            end
            ST_HALT: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_flush = 1'b1;
                halted     = 1'b1;
            end
            default: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                err        = 1'b1;
            end
        endcase
    end

endmodule
